// File: rtl/reaction_timer_core.sv
// rtl/reaction_timer_core.sv - reaction timer game engine (random wait, GO lamp, BCD ms timing)
//
// Sits between the key conditioner (one-cycle debounced pulses) and the display driver.
// A start pulse arms a pseudo-random wait; the GO lamp then lights and a BCD
// millisecond counter runs until the player reacts or the count saturates.
//
// Ports:
//   CLK_50        in   system clock, all logic on the rising edge
//   RST_N         in   asynchronous active-low reset
//   start_pulse   in   one-cycle start/restart request
//   react_pulse   in   one-cycle player reaction
//   go_led        out  high while in GO
//   result_bcd    out  {thousands,hundreds,tens,ones} ms; live in GO, held afterwards
//   result_valid  out  high in DONE
//   false_start   out  high in FOUL
//   timeout       out  high in DONE when the count saturated at 9999
//   busy          out  high in WAIT or GO
module reaction_timer_core #(
   parameter int CLK_HZ       = 50_000_000,
   parameter int SIM_MODE     = 0,
   parameter int MIN_DELAY_MS = 1000,
   parameter int RAND_BITS    = 11
) (
   input  logic        CLK_50,
   input  logic        RST_N,
   input  logic        start_pulse,
   input  logic        react_pulse,
   output logic        go_led,
   output logic [15:0] result_bcd,
   output logic        result_valid,
   output logic        false_start,
   output logic        timeout,
   output logic        busy
);

   localparam int TICK_DIV = (SIM_MODE != 0) ? 5 : CLK_HZ / 1000;
   localparam int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int DW       = $clog2(MIN_DELAY_MS + (1 << RAND_BITS) + 1);
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

   typedef enum logic [2:0] {IDLE, WAIT, GO, DONE, FOUL} state_t;

   state_t          state, state_n;
   logic [15:0]     lfsr;
   logic [PW-1:0]   presc;
   logic [DW-1:0]   delay_cnt;
   logic            tick;
   logic            enter_timed;
   logic            load_delay;
   logic            dec_delay;
   logic [15:0]     result_n;
   logic            timeout_n;

   // Add one to a 4-digit BCD value; each digit wraps 9->0 and carries upward.
   function automatic logic [15:0] bcd_inc(input logic [15:0] v);
      logic [15:0] r;
      logic        carry;
      r     = v;
      carry = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (carry) begin
            if (v[4*i +: 4] == 4'd9) begin
               r[4*i +: 4] = 4'd0;
            end else begin
               r[4*i +: 4] = v[4*i +: 4] + 4'd1;
               carry       = 1'b0;
            end
         end
      end
      return r;
   endfunction

   assign tick = (presc == PRESC_LAST);

   // The prescaler restarts whenever WAIT or GO is entered so the first ms tick
   // lands exactly TICK_DIV clocks after entry.
   assign enter_timed = (state_n != state) && ((state_n == WAIT) || (state_n == GO));

   always_ff @(posedge CLK_50 or negedge RST_N) begin
      if (!RST_N) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n    = state;
      load_delay = 1'b0;
      dec_delay  = 1'b0;
      result_n   = result_bcd;
      timeout_n  = timeout;
      case (state)
         IDLE, DONE, FOUL: begin
            // start wins over a coincident react; react alone is ignored here
            if (start_pulse) begin
               state_n    = WAIT;
               load_delay = 1'b1;
               result_n   = 16'h0000;
               timeout_n  = 1'b0;
            end
         end
         WAIT: begin
            if (react_pulse) begin
               state_n  = FOUL;
               result_n = 16'h0000;
            end else if (tick) begin
               dec_delay = 1'b1;
               if (delay_cnt == DW'(1)) begin
                  state_n  = GO;
                  result_n = 16'h0000;
               end
            end
         end
         GO: begin
            // a tick coinciding with the reaction is deliberately not counted
            if (react_pulse) begin
               state_n = DONE;
            end else if (tick) begin
               if (result_bcd == 16'h9999) begin
                  state_n   = DONE;
                  timeout_n = 1'b1;
               end else begin
                  result_n = bcd_inc(result_bcd);
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge CLK_50 or negedge RST_N) begin
      if (!RST_N) begin
         lfsr         <= 16'hACE1;
         presc        <= '0;
         delay_cnt    <= '0;
         result_bcd   <= 16'h0000;
         timeout      <= 1'b0;
         go_led       <= 1'b0;
         busy         <= 1'b0;
         result_valid <= 1'b0;
         false_start  <= 1'b0;
      end else begin
         // Fibonacci LFSR, taps 16,14,13,11, free-running in every state
         lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};

         if (enter_timed || tick) begin
            presc <= '0;
         end else begin
            presc <= presc + PW'(1);
         end

         if (load_delay) begin
            delay_cnt <= DW'(MIN_DELAY_MS) + DW'(lfsr[RAND_BITS-1:0]);
         end else if (dec_delay) begin
            delay_cnt <= delay_cnt - DW'(1);
         end

         result_bcd   <= result_n;
         timeout      <= timeout_n;
         // status outputs are decoded from the next state so they settle with it
         go_led       <= (state_n == GO);
         busy         <= (state_n == WAIT) || (state_n == GO);
         result_valid <= (state_n == DONE);
         false_start  <= (state_n == FOUL);
      end
   end

endmodule

// File: tb/tb_reaction_timer_core.sv
// tb/tb_reaction_timer_core.sv - self-checking bench for reaction_timer_core
module tb_reaction_timer_core;

   logic        CLK_50 = 1'b0;
   logic        RST_N = 1'b0;
   logic        start_pulse = 1'b0;
   logic        react_pulse = 1'b0;
   logic        go_led;
   logic [15:0] result_bcd;
   logic        result_valid;
   logic        false_start;
   logic        timeout;
   logic        busy;

   int checks = 0;
   int errors = 0;

   always #10 CLK_50 = ~CLK_50;

   reaction_timer_core #(
      .CLK_HZ      (50_000_000),
      .SIM_MODE    (1),
      .MIN_DELAY_MS(2),
      .RAND_BITS   (2)
   ) dut (
      .CLK_50      (CLK_50),
      .RST_N       (RST_N),
      .start_pulse (start_pulse),
      .react_pulse (react_pulse),
      .go_led      (go_led),
      .result_bcd  (result_bcd),
      .result_valid(result_valid),
      .false_start (false_start),
      .timeout     (timeout),
      .busy        (busy)
   );

   // Reference random source: the textbook 16-bit Fibonacci LFSR on an integer.
   int m_lfsr;
   int start_lfsr;

   function automatic int lfsr_step(input int v);
      int b;
      b = (v ^ (v >> 2) ^ (v >> 3) ^ (v >> 5)) & 1;
      return ((v >> 1) | (b << 15)) & 16'hFFFF;
   endfunction

   always @(posedge CLK_50 or negedge RST_N) begin
      if (!RST_N) begin
         m_lfsr <= 16'hACE1;
      end else begin
         if (start_pulse) start_lfsr <= m_lfsr;
         m_lfsr <= lfsr_step(m_lfsr);
      end
   end

   function automatic logic [15:0] to_bcd(input int n);
      logic [15:0] r;
      r[15:12] = 4'((n / 1000) % 10);
      r[11:8]  = 4'((n / 100) % 10);
      r[7:4]   = 4'((n / 10) % 10);
      r[3:0]   = 4'(n % 10);
      return r;
   endfunction

   // {go_led, busy, result_valid, false_start, timeout}
   function automatic logic [4:0] flags();
      return {go_led, busy, result_valid, false_start, timeout};
   endfunction

   task automatic step();
      @(posedge CLK_50);
      #1;
   endtask

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic do_start(input logic with_react, output int d);
      start_pulse = 1'b1;
      react_pulse = with_react;
      step();
      start_pulse = 1'b0;
      react_pulse = 1'b0;
      chk("start_flags", 16'(flags()), 16'b01000);
      chk("start_bcd", result_bcd, 16'h0000);
      d = 2 + (start_lfsr & 3);
   endtask

   task automatic wait_go(input int d);
      int k;
      k = 0;
      while (go_led !== 1'b1 && k <= 40) begin
         step();
         k++;
      end
      chk("go_latency", 16'(k), 16'(5 * d));
   endtask

   task automatic run_round(input logic foul, input int offs, input logic [15:0] exp_bcd);
      int   d;
      int   o;
      logic seen;
      do_start(1'b0, d);
      if (foul) begin
         o = (offs == 0) ? 5 * d : offs;
         for (int i = 1; i < o; i++) step();
         react_pulse = 1'b1;
         step();
         react_pulse = 1'b0;
         chk("foul_flags", 16'(flags()), 16'b00010);
         chk("foul_bcd", result_bcd, 16'h0000);
         seen = 1'b0;
         for (int i = 0; i < 40; i++) begin
            step();
            if (go_led) seen = 1'b1;
         end
         chk("foul_no_go", 16'(seen), 16'h0000);
      end else begin
         wait_go(d);
         seen = 1'b0;
         for (int i = 0; i < offs; i++) begin
            step();
            if (!go_led) seen = 1'b1;
         end
         chk("go_held", 16'(seen), 16'h0000);
         react_pulse = 1'b1;
         step();
         react_pulse = 1'b0;
         chk("react_bcd", result_bcd, exp_bcd);
         chk("react_flags", 16'(flags()), 16'b00100);
      end
   endtask

   typedef struct {
      logic        foul;
      int          offs;
      logic [15:0] exp_bcd;
   } vec_t;

   vec_t vecs[11];

   initial begin
      #5ms;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int   d;
      int   bad;
      int   drop_c;
      logic f;
      int   o;

      // foul offs 0 means "react exactly on the terminal wait tick"
      vecs[0]  = '{1'b0, 0,   16'h0000};
      vecs[1]  = '{1'b0, 4,   16'h0000};
      vecs[2]  = '{1'b0, 5,   16'h0001};
      vecs[3]  = '{1'b0, 9,   16'h0001};
      vecs[4]  = '{1'b0, 10,  16'h0002};
      vecs[5]  = '{1'b0, 185, 16'h0037};
      vecs[6]  = '{1'b1, 3,   16'h0000};
      vecs[7]  = '{1'b0, 57,  16'h0011};
      vecs[8]  = '{1'b1, 0,   16'h0000};
      vecs[9]  = '{1'b1, 1,   16'h0000};
      vecs[10] = '{1'b0, 249, 16'h0049};

      step();
      step();
      chk("in_reset_flags", 16'(flags()), 16'h0000);
      chk("in_reset_bcd", result_bcd, 16'h0000);
      RST_N = 1'b1;

      bad = 0;
      for (int i = 0; i < 50; i++) begin
         step();
         if (flags() !== 5'b0 || result_bcd !== 16'h0000) bad++;
      end
      chk("idle_after_reset", 16'(bad), 16'h0000);

      react_pulse = 1'b1;
      step();
      react_pulse = 1'b0;
      step();
      chk("react_in_idle_ignored", 16'(flags()), 16'h0000);

      foreach (vecs[i]) run_round(vecs[i].foul, vecs[i].offs, vecs[i].exp_bcd);

      for (int r = 0; r < 16; r++) begin
         f = ($urandom_range(0, 3) == 0);
         o = f ? int'($urandom_range(1, 10)) : int'($urandom_range(0, 260));
         run_round(f, o, f ? 16'h0000 : to_bcd(o / 5));
      end

      // start and react together from DONE/FOUL: start wins
      do_start(1'b1, d);
      wait_go(d);

      // no reaction: run to saturation, with an ignored start along the way
      drop_c = 0;
      for (int c = 1; c <= 50000; c++) begin
         step();
         start_pulse = (c == 20);
         if (drop_c == 0 && !go_led) drop_c = c;
         if (c == 21)    chk("start_in_go_ignored", 16'(flags()), 16'b11000);
         if (c == 100)   chk("go_count_100", result_bcd, to_bcd(100 / 5));
         if (c == 5000)  chk("go_count_carry", result_bcd, to_bcd(5000 / 5));
         if (c == 49994) chk("go_count_9998", result_bcd, 16'h9998);
         if (c == 49999) begin
            chk("sat_bcd", result_bcd, 16'h9999);
            chk("sat_flags", 16'(flags()), 16'b11000);
         end
         if (c == 50000) begin
            chk("timeout_flags", 16'(flags()), 16'b00101);
            chk("timeout_bcd", result_bcd, 16'h9999);
         end
      end
      chk("go_drop_cycle", 16'(drop_c), 16'(50000));
      for (int i = 0; i < 10; i++) step();
      chk("timeout_no_rollover", result_bcd, 16'h9999);

      // restart clears timeout, then reset mid-GO
      do_start(1'b0, d);
      wait_go(d);
      for (int i = 0; i < 30; i++) step();
      #4;
      RST_N = 1'b0;
      #1;
      chk("async_reset_flags", 16'(flags()), 16'h0000);
      chk("async_reset_bcd", result_bcd, 16'h0000);
      step();
      step();
      RST_N = 1'b1;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         react_pulse = (i == 5);
         if (flags() !== 5'b0 || result_bcd !== 16'h0000) bad++;
      end
      react_pulse = 1'b0;
      chk("idle_after_mid_reset", 16'(bad), 16'h0000);
      run_round(1'b0, 12, 16'h0002);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
